// File: rtl/l1_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module      : l1_assoc_cache
// Description : Set-associative L1 cache, word-granular lines, write-through
//               with no write-allocate, per-set round-robin replacement,
//               full-cache flush sweep and saturating load hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_assoc_cache #(
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  hit,
    input  logic                  flush,
    output logic                  flush_busy,
    output logic                  mem_req_valid,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_cacheable,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam int c_idx_w = $clog2(SETS);
    localparam int c_way_w = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int c_tag_w = ADDR_WIDTH - 2 - c_idx_w;

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_refill = 2'd1;
    localparam logic [1:0] c_write  = 2'd2;
    localparam logic [1:0] c_flush  = 2'd3;

    logic [1:0]            r_state;
    logic                  r_flush_pend;
    logic [c_idx_w-1:0]    r_flush_cnt;
    logic [CNT_WIDTH-1:0]  r_hit_count;
    logic [CNT_WIDTH-1:0]  r_miss_count;
    logic [WAYS-1:0]       r_valid [SETS];
    logic [c_way_w-1:0]    r_rr    [SETS];
    logic [c_tag_w-1:0]    r_tag   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] r_data  [SETS][WAYS];

    logic [c_idx_w-1:0]    w_index;
    logic [c_tag_w-1:0]    w_tag;
    logic [WAYS-1:0]       w_match;
    logic                  w_any_hit;
    logic [c_way_w-1:0]    w_hit_way;
    logic [DATA_WIDTH-1:0] w_hit_data;
    logic [c_way_w-1:0]    w_victim;
    logic [c_way_w-1:0]    w_rr_next;
    logic                  w_flush_take;
    logic                  w_idle_load_hit;
    logic                  w_unused_addr;

    // Byte offset bits are not part of a word-granular lookup.
    assign w_unused_addr = ^req_address[1:0];

    assign w_index   = req_address[2 +: c_idx_w];
    assign w_tag     = req_address[ADDR_WIDTH-1 -: c_tag_w];
    assign w_victim  = r_rr[w_index];
    assign w_rr_next = (w_victim == c_way_w'(WAYS - 1)) ? '0 : w_victim + 1'b1;

    // Per-way tag comparison against the indexed set.
    for (genvar g = 0; g < WAYS; g++) begin : g_way
        assign w_match[g] = r_valid[w_index][g] && (r_tag[w_index][g] == w_tag);
    end

    assign w_any_hit = |w_match;

    // Select the data and way number of the matching way (at most one matches).
    always_comb begin
        w_hit_data = '0;
        w_hit_way  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_match[w]) begin
                w_hit_data = r_data[w_index][w];
                w_hit_way  = c_way_w'(w);
            end
        end
    end

    // A flush (new or deferred) seen in IDLE pre-empts any request that cycle.
    assign w_flush_take    = (r_state == c_idle) && (flush || r_flush_pend);
    assign w_idle_load_hit = (r_state == c_idle) && req_valid && !req_write
                             && w_any_hit && !w_flush_take;

    assign hit        = w_idle_load_hit;
    assign flush_busy = (r_state == c_flush);
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    // Handshake and memory-side outputs decoded from the current state.
    always_comb begin
        req_ready     = 1'b0;
        rdata         = '0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_address   = '0;
        mem_wdata     = '0;
        case (r_state)
            c_idle: begin
                if (w_idle_load_hit) begin
                    req_ready = 1'b1;
                    rdata     = w_hit_data;
                end
            end
            c_refill: begin
                mem_req_valid = 1'b1;
                mem_address   = {req_address[ADDR_WIDTH-1:2], 2'b00};
                if (mem_ready) begin
                    req_ready = 1'b1;
                    rdata     = mem_rdata;
                end
            end
            c_write: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_address   = {req_address[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata     = req_wdata;
                req_ready     = mem_ready;
            end
            default: ;
        endcase
    end

    // Control state: FSM, valid bits, replacement pointers, flush sweep, counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= c_idle;
            r_flush_pend <= 1'b0;
            r_flush_cnt  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_flush_take) begin
                        r_state      <= c_flush;
                        r_flush_cnt  <= '0;
                        r_flush_pend <= 1'b0;
                    end else if (req_valid) begin
                        if (req_write) begin
                            r_state <= c_write;
                        end else if (w_any_hit) begin
                            if (r_hit_count != '1) r_hit_count <= r_hit_count + 1'b1;
                        end else begin
                            if (r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
                            r_state <= c_refill;
                        end
                    end
                end
                c_refill: begin
                    if (flush) r_flush_pend <= 1'b1;
                    if (mem_ready) begin
                        if (mem_cacheable) begin
                            r_valid[w_index][w_victim] <= 1'b1;
                            r_rr[w_index]              <= w_rr_next;
                        end
                        r_state <= c_idle;
                    end
                end
                c_write: begin
                    if (flush) r_flush_pend <= 1'b1;
                    if (mem_ready) r_state <= c_idle;
                end
                c_flush: begin
                    if (flush) r_flush_pend <= 1'b1;
                    r_valid[r_flush_cnt] <= '0;
                    r_rr[r_flush_cnt]    <= '0;
                    r_flush_cnt          <= r_flush_cnt + 1'b1;
                    if (r_flush_cnt == c_idx_w'(SETS - 1)) r_state <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    // Tag/data arrays: refill fills the victim way, a store hit updates in place.
    always_ff @(posedge clock) begin
        if (reset) begin
            if ((r_state == c_refill) && mem_ready && mem_cacheable) begin
                r_tag[w_index][w_victim]  <= w_tag;
                r_data[w_index][w_victim] <= mem_rdata;
            end
            if ((r_state == c_write) && mem_ready && w_any_hit) begin
                r_data[w_index][w_hit_way] <= req_wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l1_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_l1_assoc_cache
// Description : Self-checking bench for l1_assoc_cache (WAYS=2, SETS=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l1_assoc_cache;

    localparam int OP_RST = 0;
    localparam int OP_LD  = 1;
    localparam int OP_ST  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_address = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic [31:0] rdata;
    logic        hit;
    logic        flush = 1'b0;
    logic        flush_busy;
    logic        mem_req_valid;
    logic        mem_req_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_cacheable = 1'b0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int n_vec = 0;
    int n_err = 0;

    l1_assoc_cache #(
        .WAYS(2), .SETS(16), .ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_address(req_address),
        .req_wdata(req_wdata), .req_ready(req_ready), .rdata(rdata), .hit(hit),
        .flush(flush), .flush_busy(flush_busy),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_cacheable(mem_cacheable),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] mdata;
        logic        cach;
        logic        exp_hit;
        logic [31:0] exp_rd;
        int          exp_h;
        int          exp_m;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_counts(input string nm, input int h, input int m);
        chk({nm, ".hit_count"}, 32'(hit_count), 32'(h));
        chk({nm, ".miss_count"}, 32'(miss_count), 32'(m));
    endtask

    task automatic do_reset(input string nm);
        req_valid = 1'b0; req_write = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk({nm, ".req_ready"}, 32'(req_ready), 32'd0);
        chk({nm, ".hit"}, 32'(hit), 32'd0);
        chk({nm, ".flush_busy"}, 32'(flush_busy), 32'd0);
        chk({nm, ".mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({nm, ".rdata"}, rdata, 32'd0);
        chk_counts(nm, 0, 0);
        @(posedge clock); #1;
    endtask

    // One request: hits complete in the issue cycle; misses/stores go to memory
    // and the bench answers after lat cycles.
    task automatic xact(input string nm, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat, input logic [31:0] mdata,
                        input logic cach, input logic exp_hit, input logic [31:0] exp_rd);
        int k;
        req_valid = 1'b1; req_write = wr; req_address = addr; req_wdata = wdata;
        @(negedge clock);
        if (!wr && exp_hit) begin
            chk({nm, ".hit"}, 32'(hit), 32'd1);
            chk({nm, ".req_ready"}, 32'(req_ready), 32'd1);
            chk({nm, ".rdata"}, rdata, exp_rd);
            chk({nm, ".mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        end else begin
            chk({nm, ".hit"}, 32'(hit), 32'd0);
            chk({nm, ".req_ready"}, 32'(req_ready), 32'd0);
            k = 0;
            while (!mem_req_valid && k < 20) begin
                @(negedge clock);
                k++;
            end
            chk({nm, ".mem_req_valid"}, 32'(mem_req_valid), 32'd1);
            chk({nm, ".mem_req_write"}, 32'(mem_req_write), 32'(wr));
            chk({nm, ".mem_address"}, mem_address, addr & ~32'h3);
            if (wr) chk({nm, ".mem_wdata"}, mem_wdata, wdata);
            repeat (lat) @(negedge clock);
            mem_ready = 1'b1; mem_rdata = mdata; mem_cacheable = cach;
            #1;
            chk({nm, ".req_ready_mem"}, 32'(req_ready), 32'd1);
            if (!wr) chk({nm, ".rdata_mem"}, rdata, exp_rd);
        end
        @(posedge clock); #1;
        req_valid = 1'b0; mem_ready = 1'b0; mem_cacheable = 1'b0;
    endtask

    // Counts flush_busy cycles after the sweep starts; bounded.
    task automatic count_flush(output int cnt, output int bad);
        cnt = 0; bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (flush_busy) begin
                cnt++;
                if (req_ready || mem_req_valid) bad++;
            end else if (cnt > 0) begin
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt, bad;
        //          op      addr          wdata         lat mdata         c  hit exp_rd        h  m
        tbl[0]  = '{OP_RST, 32'h0,        32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 0};
        tbl[1]  = '{OP_LD,  32'h40,       32'h0,        3, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 0, 1};
        tbl[2]  = '{OP_LD,  32'h40,       32'h0,        0, 32'h0,        0, 1, 32'hDEADBEEF, 1, 1};
        tbl[3]  = '{OP_RST, 32'h0,        32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 0};
        tbl[4]  = '{OP_LD,  32'h40,       32'h0,        1, 32'h40404040, 1, 0, 32'h40404040, 0, 1};
        tbl[5]  = '{OP_LD,  32'h80,       32'h0,        2, 32'h80808080, 1, 0, 32'h80808080, 0, 2};
        tbl[6]  = '{OP_LD,  32'hC0,       32'h0,        0, 32'hC0C0C0C0, 1, 0, 32'hC0C0C0C0, 0, 3};
        tbl[7]  = '{OP_LD,  32'h80,       32'h0,        0, 32'h0,        0, 1, 32'h80808080, 1, 3};
        tbl[8]  = '{OP_LD,  32'h40,       32'h0,        1, 32'h40404041, 1, 0, 32'h40404041, 1, 4};
        tbl[9]  = '{OP_ST,  32'h40,       32'h12345678, 1, 32'h0,        0, 0, 32'h0,        1, 4};
        tbl[10] = '{OP_LD,  32'h40,       32'h0,        0, 32'h0,        0, 1, 32'h12345678, 2, 4};
        tbl[11] = '{OP_ST,  32'h100,      32'h55555555, 0, 32'h0,        0, 0, 32'h0,        2, 4};
        tbl[12] = '{OP_LD,  32'h100,      32'h0,        1, 32'h11110000, 1, 0, 32'h11110000, 2, 5};
        tbl[13] = '{OP_LD,  32'h2000,     32'h0,        2, 32'h000000A5, 0, 0, 32'h000000A5, 2, 6};
        tbl[14] = '{OP_LD,  32'h2000,     32'h0,        0, 32'h000000A6, 0, 0, 32'h000000A6, 2, 7};
        tbl[15] = '{OP_LD,  32'h100,      32'h0,        0, 32'h0,        0, 1, 32'h11110000, 3, 7};
        tbl[16] = '{OP_LD,  32'h40,       32'h0,        0, 32'h0,        0, 1, 32'h12345678, 4, 7};
        tbl[17] = '{OP_LD,  32'hC0,       32'h0,        0, 32'hC0C0C0C1, 1, 0, 32'hC0C0C0C1, 4, 8};
        tbl[18] = '{OP_LD,  32'h40,       32'h0,        0, 32'h40404042, 1, 0, 32'h40404042, 4, 9};
        tbl[19] = '{OP_LD,  32'hC0,       32'h0,        0, 32'h0,        0, 1, 32'hC0C0C0C1, 5, 9};
        tbl[20] = '{OP_LD,  32'h44,       32'h0,        0, 32'h00000044, 1, 0, 32'h00000044, 5, 10};
        tbl[21] = '{OP_LD,  32'h44,       32'h0,        0, 32'h0,        0, 1, 32'h00000044, 6, 10};

        for (int i = 0; i < 22; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            if (tbl[i].op == OP_RST) begin
                do_reset(nm);
            end else begin
                xact(nm, tbl[i].op == OP_ST, tbl[i].addr, tbl[i].wdata, tbl[i].lat,
                     tbl[i].mdata, tbl[i].cach, tbl[i].exp_hit, tbl[i].exp_rd);
                chk_counts(nm, tbl[i].exp_h, tbl[i].exp_m);
            end
        end

        // Flush pulse together with a load of cached 0x40: flush wins.
        req_valid = 1'b1; req_write = 1'b0; req_address = 32'h40; flush = 1'b1;
        @(negedge clock);
        chk("flushA.hit", 32'(hit), 32'd0);
        chk("flushA.req_ready", 32'(req_ready), 32'd0);
        @(posedge clock); #1;
        flush = 1'b0;
        count_flush(cnt, bad);
        chk("flushA.busy_cycles", 32'(cnt), 32'd16);
        chk("flushA.quiet", 32'(bad), 32'd0);
        chk("flushA.hit_after", 32'(hit), 32'd0);
        xact("flushA.load40", 1'b0, 32'h40, 32'h0, 1, 32'h40404043, 1'b1, 1'b0, 32'h40404043);
        xact("flushA.load44", 1'b0, 32'h44, 32'h0, 0, 32'h00000045, 1'b1, 1'b0, 32'h00000045);
        chk_counts("flushA", 6, 12);

        // Flush pulse during REFILL is deferred until the refill completes.
        req_valid = 1'b1; req_write = 1'b0; req_address = 32'h80;
        @(negedge clock);
        chk("flushB.miss", 32'(hit), 32'd0);
        @(posedge clock); #1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        @(negedge clock);
        chk("flushB.busy_in_refill", 32'(flush_busy), 32'd0);
        chk("flushB.mem_req_valid", 32'(mem_req_valid), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'h88888888; mem_cacheable = 1'b1;
        #1;
        chk("flushB.req_ready", 32'(req_ready), 32'd1);
        chk("flushB.rdata", rdata, 32'h88888888);
        @(posedge clock); #1;
        mem_ready = 1'b0; req_valid = 1'b0;
        count_flush(cnt, bad);
        chk("flushB.busy_cycles", 32'(cnt), 32'd16);
        xact("flushB.load80", 1'b0, 32'h80, 32'h0, 0, 32'h88888889, 1'b1, 1'b0, 32'h88888889);
        chk_counts("flushB", 6, 14);

        // Reset while a refill is outstanding abandons it.
        req_valid = 1'b1; req_write = 1'b0; req_address = 32'h300;
        @(negedge clock);
        @(negedge clock);
        chk("rstR.mem_req_valid_before", 32'(mem_req_valid), 32'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clock);
        chk("rstR.mem_req_valid_after", 32'(mem_req_valid), 32'd0);
        chk_counts("rstR", 0, 0);
        xact("rstR.load80", 1'b0, 32'h80, 32'h0, 0, 32'h80800000, 1'b1, 1'b0, 32'h80800000);
        chk_counts("rstR.after", 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
